bcd_time_counter: RTL

Parametrised mixed-radix BCD time counter for up to 99:59:59. It counts up (stopwatch) or down (countdown timer), with a clock-cycle prescaler, synchronous preset load, clear, and terminal-count/overflow flags. It is the next generation of the team's fixed 4-bit display counter and drives the seven-segment digit decoders directly. Digit 0 is the least significant (seconds units).

---
 rtl/bcd_time_pkg.sv | 17 +
 rtl/bcd_digit_cell.sv | 54 +++++
 rtl/bcd_time_counter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_time_pkg.sv
// Shared types and helpers for the mixed-radix BCD time counter.
package bcd_time_pkg;

   localparam int unsigned BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   // Digits 1 and 3 are tens of seconds / tens of minutes, so they count 0..5.
   function automatic int unsigned radix_of(input int unsigned idx);
      return ((idx == 1) || (idx == 3)) ? 6 : 10;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the ripple chain: load (with clamp), increment or decrement.
module bcd_digit_cell
   import bcd_time_pkg::*;
#(
   parameter int unsigned RADIX = 10
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             step_en,
   input  logic             down,
   input  logic             carry_in,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   output logic [BCD_W-1:0] digit,
   output logic             carry_out
);

   localparam logic [BCD_W-1:0] MAX_V = BCD_W'(RADIX - 1);

   logic [BCD_W-1:0] digit_q, digit_d;
   logic             at_limit;

   // A digit rolls over (and passes carry/borrow on) at 0 when counting down, at max when counting up.
   always_comb begin
      at_limit  = down ? (digit_q == '0) : (digit_q == MAX_V);
      carry_out = carry_in & at_limit;
   end

   // Next digit value: load wins, otherwise step only when the lower digits ripple into us.
   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (step_en && carry_in) begin
         if (down) begin
            digit_d = at_limit ? MAX_V : (digit_q - BCD_W'(1));
         end else begin
            digit_d = at_limit ? '0 : (digit_q + BCD_W'(1));
         end
      end
   end

   // Digit register.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;

endmodule

// File: rtl/bcd_time_counter.sv
// Mixed-radix BCD stopwatch / countdown timer with prescaler and status pulses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | holding; prescaler frozen; waits for CounterEnable
// RUN     | prescaler advancing; digits step on each rollover
// EXPIRED | down-count hit zero; digits held at 0 until Load or Clear
module bcd_time_counter
   import bcd_time_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS = 6,
   parameter  int unsigned TICK_DIV   = 50000000,
   localparam int unsigned PRESCALE_W = $clog2(TICK_DIV + 1)
) (
   input  logic                        Clk,
   input  logic                        nReset,
   input  logic                        CounterEnable,
   input  logic                        CountDown,
   input  logic                        Load,
   input  logic                        Clear,
   input  logic [BCD_W*NUM_DIGITS-1:0] LoadValue,
   output logic [BCD_W*NUM_DIGITS-1:0] Digits,
   output logic                        Tick,
   output logic                        Done,
   output logic                        Overflow,
   output logic                        Expired
);

   localparam int unsigned DW = BCD_W * NUM_DIGITS;
   localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICK_DIV - 1);

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  tick_q, tick_d;
   logic                  done_q, done_d;
   logic                  ovf_q, ovf_d;

   logic [DW-1:0]         digits;
   logic [DW-1:0]         cell_load_val;
   logic [NUM_DIGITS:0]   carry;
   logic                  cell_load;
   logic                  all_zero;
   logic                  is_one;
   logic                  run_active;
   logic                  zero_stop;
   logic                  rollover;

   // Qualify counting: Clear/Load pre-empt any step, and a down-count already at zero never steps.
   always_comb begin
      all_zero      = (digits == '0);
      is_one        = (digits == DW'(1));
      run_active    = (state_q == RUN) && CounterEnable && !Clear && !Load;
      zero_stop     = run_active && CountDown && all_zero;
      rollover      = run_active && !zero_stop && (presc_q == PRESC_LAST);
      cell_load     = Clear | Load;
      cell_load_val = Clear ? '0 : LoadValue;
   end

   assign carry[0] = 1'b1;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_cell #(
         .RADIX (radix_of(gi))
      ) u_digit (
         .clk_sys   (Clk),
         .rst_b     (nReset),
         .step_en   (rollover),
         .down      (CountDown),
         .carry_in  (carry[gi]),
         .load      (cell_load),
         .load_val  (cell_load_val[gi*BCD_W +: BCD_W]),
         .digit     (digits[gi*BCD_W +: BCD_W]),
         .carry_out (carry[gi+1])
      );
   end

   // Next state, prescaler and registered pulse flags.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      if (Clear || Load) begin
         state_d = IDLE;
         presc_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (CounterEnable) state_d = RUN;
            end
            RUN: begin
               if (!CounterEnable) begin
                  state_d = IDLE;
               end else if (zero_stop) begin
                  state_d = EXPIRED;
                  done_d  = 1'b1;
               end else if (rollover) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  // Counting down from 1 lands on zero in this very step.
                  if (CountDown && is_one) begin
                     state_d = EXPIRED;
                     done_d  = 1'b1;
                  end
                  if (!CountDown && carry[NUM_DIGITS]) ovf_d = 1'b1;
               end else begin
                  presc_d = presc_q + PRESCALE_W'(1);
               end
            end
            EXPIRED: begin
               state_d = EXPIRED;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, prescaler and flag registers.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         presc_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Digits   = digits;
   assign Tick     = tick_q;
   assign Done     = done_q;
   assign Overflow = ovf_q;
   assign Expired  = (state_q == EXPIRED);

endmodule
